// File: rtl/ps2_key_decoder_if.sv
// Key-code bundle produced by ps2_key_decoder and consumed by directions.
// Codes 0..15 are single-cycle events; anything else means no event.
interface ps2_key_decoder_if;
    logic [4:0] KEY_PRESSED;
    logic       key_valid;
    logic       rx_error;

    modport master (
        output KEY_PRESSED,
        output key_valid,
        output rx_error
    );

    modport slave (
        input KEY_PRESSED,
        input key_valid,
        input rx_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that maps four players' movement make codes
// onto 5-bit key-code pulses in the CLOCK_50 domain.
module ps2_key_decoder #(
    parameter int         FILTER    = 8,
    parameter int         TIMEOUT   = 10000,
    parameter logic [4:0] IDLE_CODE = 5'd31
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    ps2_key_decoder_if.master key
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        BASE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic [FW-1:0] fcnt;
    logic          clk_f, clk_f_d;
    logic          fall_q;

    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          byte_stb;
    logic          err_stb;

    state_t        state, state_d;
    logic [4:0]    code_d;
    logic          hit_d;
    logic [5:0]    lut;
    logic [4:0]    key_q;
    logic          valid_q;
    logic          err_q;

    function automatic logic [5:0] plain_lut(input logic [7:0] b);
        case (b)
            8'h1D:   return {1'b1, 5'd0};
            8'h1B:   return {1'b1, 5'd1};
            8'h1C:   return {1'b1, 5'd2};
            8'h23:   return {1'b1, 5'd3};
            8'h43:   return {1'b1, 5'd8};
            8'h42:   return {1'b1, 5'd9};
            8'h3B:   return {1'b1, 5'd10};
            8'h4B:   return {1'b1, 5'd11};
            8'h75:   return {1'b1, 5'd12};
            8'h73:   return {1'b1, 5'd13};
            8'h6B:   return {1'b1, 5'd14};
            8'h74:   return {1'b1, 5'd15};
            default: return {1'b0, 5'd0};
        endcase
    endfunction

    function automatic logic [5:0] ext_lut(input logic [7:0] b);
        case (b)
            8'h75:   return {1'b1, 5'd4};
            8'h72:   return {1'b1, 5'd5};
            8'h6B:   return {1'b1, 5'd6};
            8'h74:   return {1'b1, 5'd7};
            default: return {1'b0, 5'd0};
        endcase
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only follows after FILTER equal samples in a row
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            fcnt    <= '0;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            if (clk_s2 == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER - 1)) begin
                clk_f <= clk_s2;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
            clk_f_d <= clk_f;
            fall_q  <= clk_f_d & ~clk_f;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt  <= 4'd0;
            shreg    <= 8'd0;
            par      <= 1'b0;
            tcnt     <= '0;
            byte_stb <= 1'b0;
            err_stb  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            err_stb  <= 1'b0;
            if (fall_q) begin
                tcnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!dat_s2) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {dat_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par     <= dat_s2;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    // odd parity: data plus parity carry an odd number of ones
                    if (dat_s2 && (^shreg ^ par)) byte_stb <= 1'b1;
                    else                          err_stb  <= 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    tcnt    <= '0;
                    bit_cnt <= 4'd0;
                    err_stb <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= BASE;
            key_q   <= IDLE_CODE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            key_q   <= code_d;
            valid_q <= hit_d;
            err_q   <= err_stb;
        end
    end

    always_comb begin
        state_d = state;
        code_d  = IDLE_CODE;
        hit_d   = 1'b0;
        lut     = 6'd0;
        if (err_stb) begin
            state_d = BASE;
        end else if (byte_stb) begin
            unique case (state)
                BASE: begin
                    if (shreg == 8'hE0) begin
                        state_d = EXT;
                    end else if (shreg == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        lut = plain_lut(shreg);
                    end
                end
                EXT: begin
                    if (shreg == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (shreg != 8'hE0) begin
                        lut     = ext_lut(shreg);
                        state_d = BASE;
                    end
                end
                default: state_d = BASE;
            endcase
            if (lut[5]) begin
                hit_d  = 1'b1;
                code_d = lut[4:0];
            end
        end
    end

    assign key.KEY_PRESSED = key_q;
    assign key.key_valid   = valid_q;
    assign key.rx_error    = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frames plus random byte streams,
// predicted by a prefix-flag model of the keyboard scan-code rules.
module tb_ps2_key_decoder;

    localparam int         FILTER  = 8;
    localparam int         TIMEOUT = 10000;
    localparam logic [4:0] IDLE    = 5'd31;
    localparam int         HALF    = 30;

    logic CLOCK_50;
    logic resetn;
    logic PS2_CLK;
    logic PS2_DAT;

    ps2_key_decoder_if kif ();

    ps2_key_decoder #(
        .FILTER    (FILTER),
        .TIMEOUT   (TIMEOUT),
        .IDLE_CODE (IDLE)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .key      (kif)
    );

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nerr   = 0;
    bit m_ext  = 0;
    bit m_brk  = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (kif.key_valid === 1'b1) nvalid++;
        if (kif.rx_error === 1'b1) nerr++;
        chk("valid_vs_code", 32'(kif.key_valid),
            32'(kif.KEY_PRESSED != IDLE));
    end

    function automatic int plain_tbl(input logic [7:0] b);
        case (b)
            8'h1D: return 0;  8'h1B: return 1;
            8'h1C: return 2;  8'h23: return 3;
            8'h43: return 8;  8'h42: return 9;
            8'h3B: return 10; 8'h4B: return 11;
            8'h75: return 12; 8'h73: return 13;
            8'h6B: return 14; 8'h74: return 15;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_tbl(input logic [7:0] b);
        case (b)
            8'h75: return 4; 8'h72: return 5;
            8'h6B: return 6; 8'h74: return 7;
            default: return -1;
        endcase
    endfunction

    // Scan-code rules: a byte after F0 is a release, E0 selects arrows
    function automatic int model_byte(input logic [7:0] b);
        int r;
        r = -1;
        if (m_brk) begin
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                r     = ext_tbl(b);
                m_ext = 0;
            end
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else r = plain_tbl(b);
        return r;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad,
                             input int nbits, input int half,
                             input int want_code, input bit want_err);
        logic [10:0] fr;
        int v0, e0;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        v0 = nvalid;
        e0 = nerr;
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = fr[i];
            wait_cyc(half / 2);
            PS2_CLK = 1'b0;
            if (i == 10) begin
                for (int c = 1; c <= FILTER + 6; c++) begin
                    @(posedge CLOCK_50);
                    #1;
                    if (c >= FILTER + 4) begin
                        bit on;
                        on = (c == FILTER + 5);
                        chk("lat_valid", 32'(kif.key_valid),
                            32'(on && want_code >= 0));
                        chk("lat_code", 32'(kif.KEY_PRESSED),
                            (on && want_code >= 0) ? want_code : 32'(IDLE));
                        chk("lat_err", 32'(kif.rx_error),
                            32'(on && want_err));
                    end
                end
                wait_cyc(half - FILTER - 8);
            end else begin
                wait_cyc(half);
            end
            PS2_CLK = 1'b1;
            wait_cyc(half - half / 2);
        end
        PS2_DAT = 1'b1;
        if (nbits == 11) begin
            chk("n_valid", nvalid - v0, 32'(want_code >= 0));
            chk("n_err", nerr - e0, 32'(want_err));
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad,
                         input int half);
        int code;
        if (bad) begin
            code  = -1;
            m_ext = 0;
            m_brk = 0;
        end else begin
            code = model_byte(b);
        end
        send_bits(b, bad, 11, half, code, bad);
        wait_cyc(40);
    endtask

    logic [7:0] pool [20] = '{
        8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43,
        8'h42, 8'h3B, 8'h4B, 8'h75, 8'h73, 8'h6B, 8'h74,
        8'h72, 8'hE1, 8'hAA, 8'hFA, 8'hE0, 8'hF0
    };

    initial begin
        int v0, e0;
        logic [7:0] b;
        resetn  = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (4) @(posedge CLOCK_50);
        #1;
        chk("rst_code", 32'(kif.KEY_PRESSED), 32'(IDLE));
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_err", 32'(kif.rx_error), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        wait_cyc(20);

        frame(8'h1D, 0, 1250);
        frame(8'hE0, 0, HALF);
        frame(8'h74, 0, HALF);
        frame(8'h74, 0, HALF);
        frame(8'hE0, 0, HALF);
        frame(8'h6B, 0, HALF);
        frame(8'h6B, 0, HALF);

        frame(8'hF0, 0, HALF);
        frame(8'h1D, 0, HALF);
        frame(8'hE0, 0, HALF);
        frame(8'hF0, 0, HALF);
        frame(8'h75, 0, HALF);
        frame(8'h1B, 0, HALF);

        frame(8'h23, 1, HALF);
        frame(8'h23, 0, HALF);

        frame(8'hE0, 0, HALF);
        v0 = nvalid;
        e0 = nerr;
        send_bits(8'h4B, 0, 6, HALF, -1, 0);
        wait_cyc(TIMEOUT + 100);
        chk("tmo_err", nerr - e0, 1);
        chk("tmo_valid", nvalid - v0, 0);
        m_ext = 0;
        m_brk = 0;
        frame(8'h4B, 0, HALF);

        v0 = nvalid;
        e0 = nerr;
        for (int g = 0; g < 3; g++) begin
            PS2_CLK = 1'b0;
            wait_cyc(3);
            PS2_CLK = 1'b1;
            wait_cyc(20);
        end
        wait_cyc(TIMEOUT / 50);
        chk("glitch_valid", nvalid - v0, 0);
        chk("glitch_err", nerr - e0, 0);

        frame(8'hE0, 0, HALF);
        send_bits(8'h43, 0, 6, HALF, -1, 0);
        resetn = 1'b0;
        @(posedge CLOCK_50);
        #1;
        chk("mid_rst_code", 32'(kif.KEY_PRESSED), 32'(IDLE));
        chk("mid_rst_valid", 32'(kif.key_valid), 0);
        chk("mid_rst_err", 32'(kif.rx_error), 0);
        wait_cyc(5);
        resetn = 1'b1;
        m_ext = 0;
        m_brk = 0;
        wait_cyc(20);
        frame(8'h43, 0, HALF);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 19)];
            frame(b, $urandom_range(0, 7) == 0, HALF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
